avalon_mm_axil: RTL and testbench

- Avalon-MM agent (responder) that accepts single-beat read/write commands from an Avalon-MM host and re-issues each one as one AXI4-Lite master transaction.
- Counterpart of the AXI4-Lite-to-Avalon-MM host bridge. Lets Avalon-MM fabrics reach AXI4-Lite peripherals, including the XFCP AXI4-Lite modules.
- One outstanding transaction at a time. Completion is signalled by deasserting waitrequest for exactly one cycle.

---
 rtl/avalon_mm_axil.sv | 180 ++++++++++++++++++
 tb/tb_avalon_mm_axil.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_axil.sv
// avalon_mm_axil
//
// Avalon-MM agent that takes single-beat read/write commands from an Avalon-MM
// host and replays each one as a single AXI4-Lite master transaction. Only one
// transaction is in flight at a time. The host sees completion as a single
// cycle with waitrequest low.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   a_avalon_mm_*             Avalon-MM agent side (address, byteenable,
//                             read, write, writedata, readdata, response,
//                             waitrequest)
//   m_axil_aw*/w*/b*          AXI4-Lite write address, write data and write
//                             response channels (master side)
//   m_axil_ar*/r*             AXI4-Lite read address and read data channels
//                             (master side)
//
// Every output comes straight from a flop, so there is no combinational path
// from an input to an output.

module avalon_mm_axil #(
    parameter int         ADDR_WIDTH       = 32,
    parameter int         DATA_WIDTH       = 32,
    parameter int         STRB_WIDTH       = DATA_WIDTH/8,
    parameter int         BYTEENABLE_WIDTH = DATA_WIDTH/8,
    parameter logic [2:0] AXI_PROT         = 3'b000
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [ADDR_WIDTH-1:0]       a_avalon_mm_address,
    input  logic [BYTEENABLE_WIDTH-1:0] a_avalon_mm_byteenable,
    input  logic                        a_avalon_mm_read,
    input  logic                        a_avalon_mm_write,
    input  logic [DATA_WIDTH-1:0]       a_avalon_mm_writedata,
    output logic [DATA_WIDTH-1:0]       a_avalon_mm_readdata,
    output logic [1:0]                  a_avalon_mm_response,
    output logic                        a_avalon_mm_waitrequest,

    output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
    output logic [2:0]                  m_axil_awprot,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [DATA_WIDTH-1:0]       m_axil_wdata,
    output logic [STRB_WIDTH-1:0]       m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    output logic [ADDR_WIDTH-1:0]       m_axil_araddr,
    output logic [2:0]                  m_axil_arprot,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,
    input  logic [DATA_WIDTH-1:0]       m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready
);

    localparam logic [2:0] STATE_IDLE    = 3'd0;
    localparam logic [2:0] STATE_WR_REQ  = 3'd1;
    localparam logic [2:0] STATE_WR_RESP = 3'd2;
    localparam logic [2:0] STATE_RD_REQ  = 3'd3;
    localparam logic [2:0] STATE_RD_DATA = 3'd4;
    localparam logic [2:0] STATE_DONE    = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_reg;

    // Avalon has no EXOKAY encoding, so it is reported as a plain OKAY.
    function automatic logic [1:0] map_resp(input logic [1:0] axi_resp);
        return (axi_resp == 2'b01) ? 2'b00 : axi_resp;
    endfunction

    // Only one transaction is ever in flight, so a single captured address
    // feeds both the write and the read address channels.
    assign m_axil_awaddr = addr_reg;
    assign m_axil_araddr = addr_reg;
    assign m_axil_awprot = AXI_PROT;
    assign m_axil_arprot = AXI_PROT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= STATE_IDLE;
            addr_reg                <= '0;
            m_axil_wdata            <= '0;
            m_axil_wstrb            <= '0;
            m_axil_awvalid          <= 1'b0;
            m_axil_wvalid           <= 1'b0;
            m_axil_bready           <= 1'b0;
            m_axil_arvalid          <= 1'b0;
            m_axil_rready           <= 1'b0;
            a_avalon_mm_readdata    <= '0;
            a_avalon_mm_response    <= 2'b00;
            a_avalon_mm_waitrequest <= 1'b1;
        end else begin
            case (state)
                // A write takes priority if the host illegally raises read and
                // write together. AW and W go out in the same cycle.
                STATE_IDLE: begin
                    a_avalon_mm_waitrequest <= 1'b1;
                    if (a_avalon_mm_write) begin
                        addr_reg       <= a_avalon_mm_address;
                        m_axil_wdata   <= a_avalon_mm_writedata;
                        m_axil_wstrb   <= a_avalon_mm_byteenable;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid  <= 1'b1;
                        state          <= STATE_WR_REQ;
                    end else if (a_avalon_mm_read) begin
                        addr_reg       <= a_avalon_mm_address;
                        m_axil_arvalid <= 1'b1;
                        state          <= STATE_RD_REQ;
                    end
                end

                // AW and W retire independently. A valid that is already low
                // means its handshake finished in an earlier cycle.
                STATE_WR_REQ: begin
                    if (m_axil_awvalid && m_axil_awready) begin
                        m_axil_awvalid <= 1'b0;
                    end
                    if (m_axil_wvalid && m_axil_wready) begin
                        m_axil_wvalid <= 1'b0;
                    end
                    if ((!m_axil_awvalid || m_axil_awready) &&
                        (!m_axil_wvalid || m_axil_wready)) begin
                        m_axil_bready <= 1'b1;
                        state         <= STATE_WR_RESP;
                    end
                end

                STATE_WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready           <= 1'b0;
                        a_avalon_mm_response    <= map_resp(m_axil_bresp);
                        a_avalon_mm_waitrequest <= 1'b0;
                        state                   <= STATE_DONE;
                    end
                end

                STATE_RD_REQ: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= STATE_RD_DATA;
                    end
                end

                STATE_RD_DATA: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready           <= 1'b0;
                        a_avalon_mm_readdata    <= m_axil_rdata;
                        a_avalon_mm_response    <= map_resp(m_axil_rresp);
                        a_avalon_mm_waitrequest <= 1'b0;
                        state                   <= STATE_DONE;
                    end
                end

                // The single completion cycle. No new command is captured
                // here, so a host that drops its request early is ignored.
                STATE_DONE: begin
                    a_avalon_mm_waitrequest <= 1'b1;
                    state                   <= STATE_IDLE;
                end

                default: begin
                    m_axil_awvalid          <= 1'b0;
                    m_axil_wvalid           <= 1'b0;
                    m_axil_bready           <= 1'b0;
                    m_axil_arvalid          <= 1'b0;
                    m_axil_rready           <= 1'b0;
                    a_avalon_mm_waitrequest <= 1'b1;
                    state                   <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mm_axil.sv
// tb_avalon_mm_axil
//
// Self-checking bench for avalon_mm_axil. An Avalon host task issues directed
// commands and pushes the expected responses into queues. A separate monitor,
// sampling on the falling edge, pops those queues and compares them whenever
// the DUT completes an Avalon command or makes an AXI handshake. An AXI4-Lite
// slave model with per-channel ready delays and a small memory sits on the
// master side.

module tb_avalon_mm_axil;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] address    = '0;
    logic [3:0]  byteenable = '0;
    logic        read       = 1'b0;
    logic        write      = 1'b0;
    logic [31:0] writedata  = '0;
    logic [31:0] readdata;
    logic [1:0]  response;
    logic        waitrequest;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    always #5 clk = ~clk;

    avalon_mm_axil dut (
        .clk                     (clk),
        .rst                     (rst),
        .a_avalon_mm_address     (address),
        .a_avalon_mm_byteenable  (byteenable),
        .a_avalon_mm_read        (read),
        .a_avalon_mm_write       (write),
        .a_avalon_mm_writedata   (writedata),
        .a_avalon_mm_readdata    (readdata),
        .a_avalon_mm_response    (response),
        .a_avalon_mm_waitrequest (waitrequest),
        .m_axil_awaddr           (awaddr),
        .m_axil_awprot           (awprot),
        .m_axil_awvalid          (awvalid),
        .m_axil_awready          (awready),
        .m_axil_wdata            (wdata),
        .m_axil_wstrb            (wstrb),
        .m_axil_wvalid           (wvalid),
        .m_axil_wready           (wready),
        .m_axil_bresp            (bresp),
        .m_axil_bvalid           (bvalid),
        .m_axil_bready           (bready),
        .m_axil_araddr           (araddr),
        .m_axil_arprot           (arprot),
        .m_axil_arvalid          (arvalid),
        .m_axil_arready          (arready),
        .m_axil_rdata            (rdata),
        .m_axil_rresp            (rresp),
        .m_axil_rvalid           (rvalid),
        .m_axil_rready           (rready)
    );

    // ---------------- AXI4-Lite slave model ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          ar_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    bit          rd_stall  = 1'b0;

    int          aw_wait, w_wait, ar_wait;
    int          aw_count = 0;
    int          w_count  = 0;
    int          ar_count = 0;
    logic        aw_got, w_got;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] init_mem [0:63];
    logic [31:0] mem [0:63];
    logic        mem_written [0:63];

    logic [31:0] eff_awaddr, eff_wdata;
    logic [3:0]  eff_wstrb;
    logic [5:0]  wr_idx;
    logic [31:0] old_word;

    // Ready rises once the valid has waited the configured number of cycles.
    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid  && (w_wait  >= w_delay);
    assign arready = arvalid && (ar_wait >= ar_delay);

    assign eff_awaddr = aw_got ? cap_awaddr : awaddr;
    assign eff_wdata  = w_got  ? cap_wdata  : wdata;
    assign eff_wstrb  = w_got  ? cap_wstrb  : wstrb;
    assign wr_idx     = eff_awaddr[7:2];
    assign old_word   = mem_written[wr_idx] ? mem[wr_idx] : init_mem[wr_idx];

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // The response is driven the cycle after the last request handshake.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_wait    <= 0;
            w_wait     <= 0;
            ar_wait    <= 0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            cap_awaddr <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            bvalid     <= 1'b0;
            bresp      <= 2'b00;
            rvalid     <= 1'b0;
            rdata      <= '0;
            rresp      <= 2'b00;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid  && !wready)  ? w_wait  + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (awvalid && awready) begin
                aw_got     <= 1'b1;
                cap_awaddr <= awaddr;
                aw_count   <= aw_count + 1;
            end
            if (wvalid && wready) begin
                w_got     <= 1'b1;
                cap_wdata <= wdata;
                cap_wstrb <= wstrb;
                w_count   <= w_count + 1;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                aw_got              <= 1'b0;
                w_got               <= 1'b0;
                bvalid              <= 1'b1;
                bresp               <= cfg_bresp;
                mem[wr_idx]         <= merge(old_word, eff_wdata, eff_wstrb);
                mem_written[wr_idx] <= 1'b1;
            end
            if (arvalid && arready) begin
                ar_count <= ar_count + 1;
                if (!rd_stall) begin
                    rvalid <= 1'b1;
                    rdata  <= mem_written[araddr[7:2]] ? mem[araddr[7:2]] : init_mem[araddr[7:2]];
                    rresp  <= cfg_rresp;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          start_cyc;
        int          latency;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] model_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [63:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected no event", name, actual);
    endtask

    // Issue one Avalon command and hold it until the completion cycle has
    // been seen. The call returns 1 time unit after the edge that closes
    // that cycle, so back-to-back calls keep the bridge at full throughput.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] be,
                                 input logic [1:0] exp_resp, input logic [31:0] rd_expect,
                                 input int latency);
        exp_t e;
        bit   seen;
        if (wr) begin
            exp_aw_q.push_back(addr);
            exp_w_q.push_back({be, data});
        end else begin
            exp_ar_q.push_back(addr);
            model_rdata = rd_expect;
        end
        e.rdata     = model_rdata;
        e.resp      = exp_resp;
        e.start_cyc = cyc;
        e.latency   = latency;
        exp_q.push_back(e);
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = data;
        byteenable = be;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (!waitrequest) seen = 1'b1;
        end
        if (!seen) reportUnexpected("completion timeout (waitrequest stuck high)", 64'(waitrequest));
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    // The monitor samples on the falling edge. Values there equal what the
    // next rising edge will capture.
    initial begin
        exp_t e;
        bit   prev_low;
        prev_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_low = 1'b0;
            end else begin
                if (awvalid && awready) begin
                    if (exp_aw_q.size() == 0) reportUnexpected("unexpected AW handshake", 64'(awaddr));
                    else checkOutput("awaddr", 64'(awaddr), 64'(exp_aw_q.pop_front()));
                    checkOutput("awprot", 64'(awprot), 64'(0));
                end
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) reportUnexpected("unexpected W handshake", 64'(wdata));
                    else checkOutput("wstrb/wdata", 64'({wstrb, wdata}), 64'(exp_w_q.pop_front()));
                end
                if (arvalid && arready) begin
                    if (exp_ar_q.size() == 0) reportUnexpected("unexpected AR handshake", 64'(araddr));
                    else checkOutput("araddr", 64'(araddr), 64'(exp_ar_q.pop_front()));
                    checkOutput("arprot", 64'(arprot), 64'(0));
                end
                if (!waitrequest) begin
                    checkOutput("waitrequest low one cycle", 64'(prev_low), 64'(0));
                    checkOutput("AXI handshakes idle at completion",
                                64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
                    if (exp_q.size() == 0) begin
                        reportUnexpected("unexpected completion", 64'(response));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("response", 64'(response), 64'(e.resp));
                        checkOutput("readdata", 64'(readdata), 64'(e.rdata));
                        if (e.latency >= 0)
                            checkOutput("latency", 64'(cyc - e.start_cyc), 64'(e.latency));
                    end
                end
                prev_low = !waitrequest;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit got;
        for (int i = 0; i < 64; i++) begin
            init_mem[i]    = '0;
            mem_written[i] = 1'b0;
        end
        init_mem[8] = 32'h1234_5678;
        init_mem[2] = 32'h0BAD_F00D;

        // The reset is asserted away from a clock edge, so it must act asynchronously.
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset waitrequest", 64'(waitrequest), 64'(1));
        checkOutput("reset valids/readies", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
        checkOutput("reset readdata", 64'(readdata), 64'(0));
        checkOutput("reset response", 64'(response), 64'(0));
        checkOutput("reset addr/data/strb", {awaddr, wdata[27:0], wstrb}, 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] zero-wait write");
        applyStimulus(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, '0, 3);

        $display("[TB] read with AR stall, SLVERR");
        ar_delay = 5; cfg_rresp = 2'b10;
        applyStimulus(1, 0, 32'h0000_0020, '0, 4'h0, 2'b10, 32'h1234_5678, 8);
        ar_delay = 0; cfg_rresp = 2'b00;

        $display("[TB] staggered AW/W handshakes");
        aw_delay = 4; w_delay = 0; cfg_bresp = 2'b11;
        applyStimulus(0, 1, 32'h0000_0044, 32'hA5A5_0F0F, 4'h3, 2'b11, '0, 7);
        aw_delay = 0; w_delay = 3; cfg_bresp = 2'b01;
        applyStimulus(0, 1, 32'h0000_0048, 32'h0000_1111, 4'hF, 2'b00, '0, 6);
        w_delay = 0; cfg_bresp = 2'b00;

        $display("[TB] read and write together");
        applyStimulus(1, 1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 2'b00, '0, 3);

        $display("[TB] reset during RD_DATA");
        rd_stall = 1'b1;
        exp_ar_q.push_back(32'h0000_0030);
        read    = 1'b1;
        address = 32'h0000_0030;
        got     = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rready) got = 1'b1;
        end
        checkOutput("reached RD_DATA", 64'(got), 64'(1));
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("async reset waitrequest", 64'(waitrequest), 64'(1));
        checkOutput("async reset rready", 64'(rready), 64'(0));
        checkOutput("async reset readdata", 64'(readdata), 64'(0));
        read        = 1'b0;
        model_rdata = '0;
        #2 rst = 1'b1;
        rd_stall = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 32'h0000_0008, '0, 4'h0, 2'b00, 32'h0BAD_F00D, 3);

        $display("[TB] back-to-back write/read, EXOKAY reads");
        cfg_rresp = 2'b01;
        applyStimulus(0, 1, 32'h0000_0000, 32'h1111_0000, 4'hF, 2'b00, '0, 3);
        applyStimulus(1, 0, 32'h0000_0000, '0, 4'h0, 2'b00, 32'h1111_0000, 3);
        applyStimulus(0, 1, 32'h0000_0004, 32'h2222_0004, 4'hC, 2'b00, '0, 3);
        applyStimulus(1, 0, 32'h0000_0004, '0, 4'h0, 2'b00, 32'h2222_0000, 3);
        applyStimulus(0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 2'b00, '0, 3);
        applyStimulus(1, 0, 32'h0000_0000, '0, 4'h0, 2'b00, 32'h1111_0000, 3);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("pending completions", 64'(exp_q.size()), 64'(0));
        checkOutput("pending AW/W/AR", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'(0));
        checkOutput("AW handshake count", 64'(aw_count), 64'(7));
        checkOutput("W handshake count", 64'(w_count), 64'(7));
        checkOutput("AR handshake count", 64'(ar_count), 64'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
